// File: rtl/itch_msg_latch_fifo_pkg.sv
// itch_msg_latch_fifo_pkg: ITCH field widths, entry layout and message type codes
package itch_msg_latch_fifo_pkg;
  localparam int TYPE_W   = 4;
  localparam int REF_W    = 64;
  localparam int SHARES_W = 32;
  localparam int PRICE_W  = 32;
  localparam int TS_W     = 48;
  localparam int MISC_W   = 64;
  localparam int ENTRY_W  = TYPE_W + 2 * REF_W + 1 + SHARES_W + PRICE_W + TS_W + MISC_W;
  typedef enum logic [TYPE_W-1:0] {
    MT_NONE       = 4'h0,
    MT_ADD        = 4'h1,
    MT_ADD_MPID   = 4'h2,
    MT_EXEC       = 4'h3,
    MT_EXEC_PRICE = 4'h4,
    MT_CANCEL     = 4'h5,
    MT_DELETE     = 4'h6,
    MT_REPLACE    = 4'h7,
    MT_TRADE      = 4'h8
  } itch_type_e;
  typedef struct packed {
    logic [TYPE_W-1:0]   msg_type;
    logic [REF_W-1:0]    order_ref;
    logic                side;
    logic [SHARES_W-1:0] shares;
    logic [PRICE_W-1:0]  price;
    logic [REF_W-1:0]    new_order_ref;
    logic [TS_W-1:0]     timestamp;
    logic [MISC_W-1:0]   misc_data;
  } itch_msg_t;
endpackage

// File: rtl/itch_sync_fifo.sv
// itch_sync_fifo: generic synchronous FIFO with level-based full/empty and registered head
module itch_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   head_valid_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q;
  logic head_valid_q, do_push, do_pop;
  // pop only when something is held; push when room exists or a pop frees a slot this cycle
  always_comb begin
    do_pop   = pop_i && (level_q != '0);
    do_push  = push_i && ((level_q != LW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end
  // storage needs no reset: the level alone decides which slots are live
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  // pointers, level and the head copy, which follows the read pointer one cycle later and holds when empty
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      head_q       <= (level_q != '0) ? mem_q[rd_ptr_q] : head_q;
      head_valid_q <= level_q != '0;
    end
  assign head_o       = head_q;
  assign head_valid_o = head_valid_q;
  assign level_o      = level_q;
endmodule

// File: rtl/itch_msg_latch_fifo.sv
// itch_msg_latch_fifo: buffers parsed ITCH messages for the register slave and accounts for drops
module itch_msg_latch_fifo
  import itch_msg_latch_fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    parsed_valid,
  input  logic [3:0]              parsed_type,
  input  logic [63:0]             parsed_order_ref,
  input  logic                    parsed_side,
  input  logic [31:0]             parsed_shares,
  input  logic [31:0]             parsed_price,
  input  logic [63:0]             parsed_new_order_ref,
  input  logic [47:0]             parsed_timestamp,
  input  logic [63:0]             parsed_misc_data,
  input  logic                    pop,
  input  logic                    clear_stats,
  output logic                    latched_valid,
  output logic [3:0]              latched_type,
  output logic [63:0]             latched_order_ref,
  output logic                    latched_side,
  output logic [31:0]             latched_shares,
  output logic [31:0]             latched_price,
  output logic [63:0]             latched_new_order_ref,
  output logic [47:0]             latched_timestamp,
  output logic [63:0]             latched_misc_data,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count
);
  localparam int LW = $clog2(DEPTH) + 1;
  itch_msg_t wr_msg, head;
  logic drop, overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
  assign wr_msg = '{parsed_type, parsed_order_ref, parsed_side, parsed_shares, parsed_price,
                    parsed_new_order_ref, parsed_timestamp, parsed_misc_data};
  assign drop = parsed_valid && (fill_level == LW'(DEPTH)) && !pop;
  // a drop outranks clear_stats, so a clear in the same cycle leaves a count of one
  always_comb begin
    drop_count_d = drop ? (clear_stats ? DROP_CNT_W'(1) : (&drop_count_q ? drop_count_q : drop_count_q + DROP_CNT_W'(1)))
                        : (clear_stats ? '0 : drop_count_q);
    overflow_d   = drop || (overflow_q && !clear_stats);
  end
  // drop statistics
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  itch_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i        (S_AXI_ACLK),
    .rst_ni       (S_AXI_ARESETN),
    .push_i       (parsed_valid),
    .pop_i        (pop),
    .data_i       (wr_msg),
    .head_o       (head),
    .head_valid_o (latched_valid),
    .level_o      (fill_level)
  );
  assign latched_type          = head.msg_type;
  assign latched_order_ref     = head.order_ref;
  assign latched_side          = head.side;
  assign latched_shares        = head.shares;
  assign latched_price         = head.price;
  assign latched_new_order_ref = head.new_order_ref;
  assign latched_timestamp     = head.timestamp;
  assign latched_misc_data     = head.misc_data;
  assign overflow              = overflow_q;
  assign drop_count            = drop_count_q;
endmodule

// File: tb/tb_itch_msg_latch_fifo.sv
// tb_itch_msg_latch_fifo: randomized and directed checks against a queue-based reference model
module tb_itch_msg_latch_fifo;
  import itch_msg_latch_fifo_pkg::*;
  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int DMAX  = (1 << DW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic pv = 1'b0, pop = 1'b0, clr = 1'b0;
  itch_msg_t msg = '0;
  logic lv, l_side, ovf;
  logic [3:0] l_type;
  logic [63:0] l_ref, l_nref, l_misc;
  logic [31:0] l_shares, l_price;
  logic [47:0] l_ts;
  logic [$clog2(DEPTH):0] fill;
  logic [DW-1:0] drops;
  itch_msg_t q[$];
  itch_msg_t exp_lat = '0;
  logic exp_v = 1'b0, exp_ovf = 1'b0;
  int exp_drop = 0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  itch_msg_latch_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .parsed_valid(pv),
    .parsed_type(msg.msg_type), .parsed_order_ref(msg.order_ref), .parsed_side(msg.side),
    .parsed_shares(msg.shares), .parsed_price(msg.price), .parsed_new_order_ref(msg.new_order_ref),
    .parsed_timestamp(msg.timestamp), .parsed_misc_data(msg.misc_data),
    .pop(pop), .clear_stats(clr), .latched_valid(lv), .latched_type(l_type),
    .latched_order_ref(l_ref), .latched_side(l_side), .latched_shares(l_shares),
    .latched_price(l_price), .latched_new_order_ref(l_nref), .latched_timestamp(l_ts),
    .latched_misc_data(l_misc), .fill_level(fill), .overflow(ovf), .drop_count(drops)
  );
  task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_valid"}, ENTRY_W'(lv), ENTRY_W'(exp_v));
    chk({tag, "_level"}, ENTRY_W'(fill), ENTRY_W'(q.size()));
    chk({tag, "_ovf"}, ENTRY_W'(ovf), ENTRY_W'(exp_ovf));
    chk({tag, "_drops"}, ENTRY_W'(drops), ENTRY_W'(exp_drop));
    chk({tag, "_head"}, {l_type, l_ref, l_side, l_shares, l_price, l_nref, l_ts, l_misc}, exp_lat);
  endtask
  function automatic itch_msg_t rnd_msg();
    logic [319:0] w;
    for (int i = 0; i < 10; i++) w[i*32 +: 32] = $urandom;
    return itch_msg_t'(w[ENTRY_W-1:0]);
  endfunction
  function automatic itch_msg_t ref_msg(input logic [63:0] r);
    itch_msg_t m;
    m = rnd_msg();
    m.order_ref = r;
    return m;
  endfunction
  // one clock with the given inputs; the model works from the queue as it stood before the edge
  task automatic step(input logic v, input itch_msg_t m, input logic p, input logic c, input string tag);
    int sz;
    pv = v; msg = m; pop = p; clr = c;
    @(posedge clk);
    sz = q.size();
    exp_v = sz > 0;
    if (sz > 0) exp_lat = q[0];
    if (c) begin exp_drop = 0; exp_ovf = 1'b0; end
    if (p && sz > 0) q.delete(0);
    if (v) begin
      if (sz < DEPTH || p) q.push_back(m);
      else begin
        exp_ovf = 1'b1;
        exp_drop = (exp_drop < DMAX) ? exp_drop + 1 : exp_drop;
      end
    end
    #1;
    pv = 1'b0; pop = 1'b0; clr = 1'b0;
    chk_all(tag);
  endtask
  task automatic model_reset();
    q.delete();
    exp_lat = '0; exp_v = 1'b0; exp_ovf = 1'b0; exp_drop = 0;
  endtask
  initial begin
    itch_msg_t m;
    #12;
    chk_all("reset");
    @(negedge clk) rst_n = 1'b1;
    m = '0; m.msg_type = 4'h1; m.price = 32'h000186A0; m.shares = 32'd100;
    step(1, m, 0, 0, "push1");
    step(0, '0, 0, 0, "push1_lat");
    chk("push1_price", ENTRY_W'(l_price), ENTRY_W'(32'h000186A0));
    step(0, '0, 1, 0, "pop1");
    step(0, '0, 0, 0, "pop1_lat");
    chk("pop1_valid", ENTRY_W'(lv), ENTRY_W'(0));
    for (int i = 1; i <= 8; i++) step(1, ref_msg(64'(i)), 0, 0, "fill");
    step(1, ref_msg(64'd100), 0, 0, "drop9");
    chk("full_level", ENTRY_W'(fill), ENTRY_W'(DEPTH));
    chk("full_drops", ENTRY_W'(drops), ENTRY_W'(1));
    chk("full_head", ENTRY_W'(l_ref), ENTRY_W'(1));
    step(1, ref_msg(64'd9), 1, 0, "full_pushpop");
    step(0, '0, 0, 0, "full_pushpop_lat");
    chk("pp_head", ENTRY_W'(l_ref), ENTRY_W'(2));
    chk("pp_drops", ENTRY_W'(drops), ENTRY_W'(1));
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0, "drain");
    step(0, '0, 1, 0, "pop_empty");
    step(1, ref_msg(64'hAA), 1, 0, "pushpop_empty");
    step(0, '0, 0, 0, "pushpop_empty_lat");
    chk("aa_head", ENTRY_W'(l_ref), ENTRY_W'(64'hAA));
    for (int i = 0; i < 7; i++) step(1, rnd_msg(), 0, 0, "refill");
    for (int i = 0; i < 20; i++) step(1, rnd_msg(), 0, 0, "drops");
    chk("sat_drops", ENTRY_W'(drops), ENTRY_W'(4'hF));
    step(0, '0, 0, 1, "clear");
    chk("clear_drops", ENTRY_W'(drops), ENTRY_W'(0));
    step(1, rnd_msg(), 0, 1, "clear_drop");
    chk("cd_drops", ENTRY_W'(drops), ENTRY_W'(1));
    chk("cd_ovf", ENTRY_W'(ovf), ENTRY_W'(1));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd_msg(), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, "rand");
    for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1, 0, "drain2");
    for (int i = 0; i < 5; i++) step(1, rnd_msg(), 0, 0, "five");
    step(0, '0, 0, 0, "five_lat");
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all("async_reset");
    @(negedge clk) rst_n = 1'b1;
    step(1, ref_msg(64'h55), 0, 0, "post_reset");
    step(0, '0, 0, 0, "post_reset_lat");
    chk("h55_head", ENTRY_W'(l_ref), ENTRY_W'(64'h55));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
